// File: rtl/pp_ball_ctrl_pkg.sv
// Shared types and constants for the ping-pong ball/score datapath.
package pp_pkg;

    // Game state codes as produced by the external state register.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'b000,
        ST_RIGHT  = 3'b001,
        ST_LEFT   = 3'b010,
        ST_PTA    = 3'b011,
        ST_PTB    = 3'b100,
        ST_OVER   = 3'b101,
        ST_FRIGHT = 3'b110,
        ST_FLEFT  = 3'b111
    } pp_state_e;

    localparam logic [5:0] LED_A_END = 6'b000001;
    localparam logic [5:0] LED_B_END = 6'b100000;
    localparam logic [5:0] LED_OFF   = 6'b000000;
    localparam logic [5:0] LED_ALL   = 6'b111111;

    localparam logic [3:0] SCORE_MAX = 4'd9;

    // Ball travelling toward the bit5 (player B) end.
    function automatic logic is_right(pp_state_e s);
        return (s == ST_RIGHT) || (s == ST_FRIGHT);
    endfunction

    // Ball travelling toward the bit0 (player A) end.
    function automatic logic is_left(pp_state_e s);
        return (s == ST_LEFT) || (s == ST_FLEFT);
    endfunction

    // Fast states step at half the current period.
    function automatic logic is_fast(pp_state_e s);
        return (s == ST_FRIGHT) || (s == ST_FLEFT);
    endfunction

endpackage

// File: rtl/pp_ball_ctrl_if.sv
// Bus between the game state register/next-state logic and the ball datapath.
interface pp_ball_ctrl_if;

    logic [2:0] CS;
    logic [5:0] LED;
    logic [3:0] SCOREA;
    logic [3:0] SCOREB;

    // State-logic side: drives the state, observes ball and scores.
    modport master (output CS, input LED, SCOREA, SCOREB);
    // Datapath side: follows the state, owns ball and scores.
    modport slave (input CS, output LED, SCOREA, SCOREB);

endinterface

// File: rtl/pp_ball_ctrl_step_timer.sv
// Ball-step prescaler: counts 0..period-1 and pulses tick in the last cycle.
module pp_step_timer #(
    parameter int unsigned WIDTH = 25
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] period,
    input  logic             clear,
    input  logic             enable,
    output logic             tick
);

    logic [WIDTH-1:0] count;

    // >= guards against the period shrinking below the running count.
    assign tick = enable && !clear && (count >= period - WIDTH'(1));

    // Count while enabled; clear, disable and wrap all return to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || !enable || tick) begin
            count <= '0;
        end else begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pp_ball_ctrl.sv
// Ball position and BCD score datapath for the ping-pong game.
// Optional feature: define PP_SPEEDUP_EN to shorten the step period on each return.
module pp_ball_ctrl
    import pp_pkg::*;
#(
    parameter int unsigned STEP_DIV = 25000000
) (
    input logic           CLK,
    input logic           RST_N,
    pp_ball_ctrl_if.slave bus
);

    localparam int unsigned   PW     = $clog2(STEP_DIV + 1);
    localparam logic [PW-1:0] P_FULL = PW'(STEP_DIV);

    pp_state_e     cs;
    pp_state_e     prev_cs;
    logic          state_change;
    logic          timer_en;
    logic          tick;
    logic [PW-1:0] period_base;
    logic [PW-1:0] timer_period;
    logic [5:0]    led;
    logic [3:0]    score_a;
    logic [3:0]    score_b;

    assign cs           = pp_state_e'(bus.CS);
    assign state_change = (cs != prev_cs);
    assign timer_en     = is_right(cs) || is_left(cs) || (cs == ST_OVER);
    assign timer_period = is_fast(cs) ? (period_base >> 1) : period_base;

`ifdef PP_SPEEDUP_EN
    localparam logic [PW-1:0] P_DEC = PW'(STEP_DIV / 8);
    localparam logic [PW-1:0] P_MIN = PW'(STEP_DIV / 4);

    logic is_return;

    // A return flips the ball between the two direction groups.
    assign is_return = (is_right(prev_cs) && is_left(cs)) || (is_left(prev_cs) && is_right(cs));

    // Rally speeds up on each return down to a floor; a point restores full period.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            period_base <= P_FULL;
        end else if (state_change && ((cs == ST_PTA) || (cs == ST_PTB))) begin
            period_base <= P_FULL;
        end else if (is_return) begin
            if (period_base >= P_MIN + P_DEC) begin
                period_base <= period_base - P_DEC;
            end else begin
                period_base <= P_MIN;
            end
        end
    end
`else
    assign period_base = P_FULL;
`endif

    // Any state change restarts the step count, so it overrides a coincident tick.
    pp_step_timer #(
        .WIDTH (PW)
    ) u_step_timer (
        .clk    (CLK),
        .rst_n  (RST_N),
        .period (timer_period),
        .clear  (state_change),
        .enable (timer_en),
        .tick   (tick)
    );

    // Ball position, scores and state-entry tracking.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            prev_cs <= ST_IDLE;
            led     <= LED_OFF;
            score_a <= '0;
            score_b <= '0;
        end else begin
            prev_cs <= cs;
            case (cs)
                ST_RIGHT, ST_FRIGHT: begin
                    if (state_change) begin
                        if (prev_cs == ST_IDLE && cs == ST_RIGHT) begin
                            led <= LED_A_END;
                        end
                    end else if (tick && !led[5]) begin
                        led <= {led[4:0], 1'b0};
                    end
                end
                ST_LEFT, ST_FLEFT: begin
                    if (state_change) begin
                        if (prev_cs == ST_IDLE && cs == ST_LEFT) begin
                            led <= LED_B_END;
                        end
                    end else if (tick && !led[0]) begin
                        led <= {1'b0, led[5:1]};
                    end
                end
                ST_PTA: begin
                    led <= LED_OFF;
                    if (state_change && score_a != SCORE_MAX) begin
                        score_a <= score_a + 4'd1;
                    end
                end
                ST_PTB: begin
                    led <= LED_OFF;
                    if (state_change && score_b != SCORE_MAX) begin
                        score_b <= score_b + 4'd1;
                    end
                end
                ST_OVER: begin
                    if (state_change) begin
                        led <= LED_ALL;
                    end else if (tick) begin
                        led <= ~led;
                    end
                end
                default: begin
                    led <= LED_OFF;
                end
            endcase
        end
    end

    assign bus.LED    = led;
    assign bus.SCOREA = score_a;
    assign bus.SCOREB = score_b;

endmodule
